// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder, the only arithmetic element of the serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial unsigned adder: one full_adder stepped LSB first, one bit per clock.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, sum_r;
  logic             carry, cout_r;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_c;
  logic             accept, last;

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_s),
    .cout (fa_c)
  );

  assign ready  = (state == IDLE) || (state == DONE);
  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  assign accept = ready & start;
  assign last   = (cnt == CW'(WIDTH - 1));
  assign sum    = sum_r;
  assign cout   = cout_r;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_sh  <= a;
        b_sh  <= b;
        carry <= cin;
        sum_r <= '0;
        cnt   <= '0;
      end else if (state == RUN) begin
        // sum fills from the top so bit 0 lands in sum[0] after WIDTH shifts
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        sum_r  <= {fa_s, sum_r[WIDTH-1:1]};
        carry  <= fa_c;
        cout_r <= fa_c;
        if (!last) cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): vector table, corner sequences, random loop.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, cin;
  logic [W-1:0] a, b;
  logic         ready, busy, done, cout;
  logic [W-1:0] sum;

  int total = 0;
  int bad   = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Launch one operation; inputs are scrambled after capture. lat counts edges
  // from the accepting edge to the edge after which done is seen (0 = timeout).
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                       input bit scramble, output logic [W-1:0] s, output logic co,
                       output int lat, output logic busy1);
    a = ta; b = tb; cin = tc; start = 1'b1;
    lat = 0; busy1 = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (i == 1) busy1 = busy;
      if (scramble) begin
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      end
      if (done) begin
        lat = i;
        break;
      end
    end
    s = sum; co = cout;
  endtask

  vec_t         vecs[6];
  logic [W-1:0] s;
  logic         co, b1;
  int           lat, npulse;
  logic [W:0]   model;

  initial begin
    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[5] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0};

    rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", ready, 1);
    check("reset_busy",  busy,  0);
    check("reset_done",  done,  0);
    check("reset_sum",   sum,   0);
    check("reset_cout",  cout,  0);
    start = 1'b0; rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[k]) begin
      do_op(vecs[k].a, vecs[k].b, vecs[k].cin, 1'b1, s, co, lat, b1);
      check($sformatf("vec%0d_latency", k), lat, 9);
      check($sformatf("vec%0d_busy", k), b1, 1);
      check($sformatf("vec%0d_sum", k), s, vecs[k].sum);
      check($sformatf("vec%0d_cout", k), co, vecs[k].cout);
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_one_cycle", k), done, 0);
      check($sformatf("vec%0d_ready_after", k), ready, 1);
    end

    // result holds through idle cycles
    repeat (3) @(posedge clk);
    #1;
    check("idle_hold_sum", sum, vecs[5].sum);
    check("idle_hold_cout", cout, vecs[5].cout);

    // start held high through RUN, operands overwritten after capture
    a = 8'h3C; b = 8'h0F; cin = 1'b0; start = 1'b1;
    npulse = 0; lat = 0; s = '0; co = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      @(posedge clk); #1;
      if (i == 2) begin a = 8'hFF; b = 8'hFF; end
      if (done) begin
        npulse++;
        if (npulse == 1) begin lat = i; s = sum; co = cout; end
        start = 1'b0;
      end
    end
    check("held_start_pulses", npulse, 1);
    check("held_start_latency", lat, 9);
    check("held_start_sum", s, 8'h4B);
    check("held_start_cout", co, 0);

    // back-to-back: start accepted in the DONE cycle
    do_op(8'h10, 8'h20, 1'b0, 1'b0, s, co, lat, b1);
    check("b2b_first_sum", s, 8'h30);
    do_op(8'h01, 8'h01, 1'b0, 1'b0, s, co, lat, b1);
    check("b2b_busy_next", b1, 1);
    check("b2b_latency", lat, 9);
    check("b2b_sum", s, 8'h02);
    check("b2b_cout", co, 0);

    // reset in the 4th RUN cycle aborts the operation
    a = 8'h12; b = 8'h34; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ready", ready, 1);
    check("abort_busy",  busy,  0);
    check("abort_done",  done,  0);
    check("abort_sum",   sum,   0);
    check("abort_cout",  cout,  0);
    // a stale done from the aborted op would shorten the latency
    do_op(8'h80, 8'h80, 1'b0, 1'b1, s, co, lat, b1);
    check("post_abort_latency", lat, 9);
    check("post_abort_sum", s, 8'h00);
    check("post_abort_cout", co, 1);

    // reset wins over a simultaneous start
    rst = 1'b1; start = 1'b1; a = 8'h01; b = 8'h01;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("rst_priority_busy", busy, 0);

    for (int n = 0; n < 256; n++) begin
      logic [W-1:0] ra, rb;
      logic         rc;
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      model = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      do_op(ra, rb, rc, 1'b1, s, co, lat, b1);
      total++;
      if (lat != 9 || {co, s} !== model) begin
        bad++;
        $display("FAIL random%0d: %0h+%0h+%0h got={%0h,%0h} lat=%0d expected=%0h lat=9",
                 n, ra, rb, rc, co, s, lat, model);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter SHALL be: WIDTH, default 8, operand width in bits (WIDTH >= 2).
REQ-002 Port clk SHALL be: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port rst SHALL be: rst  input  1  reset, synchronous and active-high.
REQ-004 Port start SHALL be: start  input  1  request to begin an addition; sampled only when ready=1.
REQ-005 Port a SHALL be: a  input  WIDTH  operand A, captured on an accepted start.
REQ-006 Port b SHALL be: b  input  WIDTH  operand B, captured on an accepted start.
REQ-007 Port cin SHALL be: cin  input  1  carry-in, captured on an accepted start.
REQ-008 Port ready SHALL be: ready  output  1  high when start will be accepted (state IDLE or DONE).
REQ-009 Port busy SHALL be: busy  output  1  high while state is RUN.
REQ-010 Port done SHALL be: done  output  1  one-cycle pulse when sum/cout become valid.
REQ-011 Port sum SHALL be: sum  output  WIDTH  result, valid from done and held until the next accepted start.
REQ-012 Port cout SHALL be: cout  output  1  final carry-out, same validity as sum.

Function
REQ-013 The block SHALL sequence a single 1-bit full adder bit-serially, LSB first, one bit per clock.
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 IDLE with start=1 SHALL capture a, b and cin into shift registers and the carry flop, clear the bit counter and sum register, and go to RUN.
REQ-016 In each RUN cycle the block SHALL add a_sh[0] + b_sh[0] + carry, shift the sum bit into sum[WIDTH-1] (right shift), store the carry-out, shift a_sh and b_sh right, and increment the counter.
REQ-017 After the WIDTH-th RUN cycle (counter = WIDTH-1) the FSM SHALL go to DONE.
REQ-018 DONE SHALL last exactly one cycle with done=1 and SHALL then go to IDLE; start=1 in DONE SHALL be accepted and go directly to RUN.
REQ-019 Latency: start accepted at edge N SHALL give done=1 in the cycle after edge N+WIDTH.
REQ-020 start while busy=1 SHALL be ignored, with no effect on operands, counter or result.
REQ-021 Changes on a, b or cin after capture SHALL NOT affect the running result.
REQ-022 Arithmetic SHALL be unsigned: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1).
REQ-023 The counter SHALL be clog2(WIDTH) bits wide and SHALL NOT wrap during a single operation.
REQ-024 sum and cout SHALL hold their previous result in IDLE and SHALL change only during RUN.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE, ready=1, busy=0, done=0, sum=0, cout=0 and clear all shift registers, the carry flop and the counter.
REQ-026 rst during RUN SHALL abort the operation with no done pulse, and start SHALL be accepted on the first edge after rst deasserts.
REQ-027 When rst and start are high together, rst SHALL have priority.

Structure
REQ-028 Package serial_adder_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-029 The 1-bit adder SHALL be an instance of the team's existing full_adder module (ports a, b, cin, sum, cout) and SHALL be the only sub-module.
REQ-030 The datapath SHALL otherwise be flops plus next-state logic, with no multi-bit adder inferred.

Verification (WIDTH=8)
REQ-031 Bench SHALL cover: a=0x00, b=0x00, cin=0 -> done 9 cycles after start, sum=0x00, cout=0.
REQ-032 Bench SHALL cover: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; and a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1.
REQ-033 Bench SHALL cover: a=0x3C, b=0x0F, cin=0, with start held high and a/b changed to 0xFF during RUN -> sum=0x4B, cout=0, exactly one done pulse.
REQ-034 Bench SHALL cover: start asserted in the DONE cycle with a=0x01, b=0x01 -> busy the next cycle, then sum=0x02 with no IDLE cycle in between.
REQ-035 Bench SHALL cover: rst pulsed for one cycle in the 4th RUN cycle -> no done pulse, sum=0, cout=0, ready=1; a following start with 0x80+0x80 -> sum=0x00, cout=1.
REQ-036 Bench SHALL cover: a self-checking loop of 256 random operand/cin sets compared against a+b+cin -> zero mismatches.
